// File: rtl/alu_core.sv
// alu_core: 15-operation integer ALU with a combinational result and a registered copy.
// Ports: clk, reset (async, active-high), operation[3:0], A, B -> Out, Zero (comb);
//        OutReg, ZeroReg (Out/Zero captured on rising clk; 0 / 1 while reset is high).
// Latency: Out/Zero zero cycles; OutReg/ZeroReg one cycle. No flow control.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic [WIDTH-1:0] OutReg,
  output logic             ZeroReg
);

  localparam logic [3:0] ADD                        = 4'd0;
  localparam logic [3:0] SUB                        = 4'd1;
  localparam logic [3:0] OR                         = 4'd2;
  localparam logic [3:0] XOR                        = 4'd3;
  localparam logic [3:0] AND                        = 4'd4;
  localparam logic [3:0] LesserThanUnsigned         = 4'd5;
  localparam logic [3:0] LesserThanSigned           = 4'd6;
  localparam logic [3:0] ShiftRightUnsigned         = 4'd7;
  localparam logic [3:0] ShiftLeftUnsigned          = 4'd8;
  localparam logic [3:0] ShiftRightSigned           = 4'd9;
  localparam logic [3:0] ShiftLeftSigned            = 4'd10;
  localparam logic [3:0] GreaterThanOrEqualUnsigned = 4'd11;
  localparam logic [3:0] GreaterThanOrEqualSigned   = 4'd12;
  localparam logic [3:0] Equal                      = 4'd13;
  localparam logic [3:0] NotEqual                   = 4'd14;

  localparam int SHW = $clog2(WIDTH);

  // Only the low log2(WIDTH) bits of B form the shift amount; upper bits are ignored.
  logic [SHW-1:0]   shamt;
  logic             lt_u;
  logic             lt_s;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;

  assign shamt = B[SHW-1:0];
  assign lt_u  = (A < B);
  assign lt_s  = ($signed(A) < $signed(B));

  always_comb begin
    out_d = '0;
    unique case (operation)
      ADD:                        out_d = A + B;
      SUB:                        out_d = A - B;
      OR:                         out_d = A | B;
      XOR:                        out_d = A ^ B;
      AND:                        out_d = A & B;
      LesserThanUnsigned:         out_d = {{(WIDTH-1){1'b0}}, lt_u};
      LesserThanSigned:           out_d = {{(WIDTH-1){1'b0}}, lt_s};
      ShiftRightUnsigned:         out_d = A >> shamt;
      ShiftLeftUnsigned:          out_d = A << shamt;
      ShiftRightSigned:           out_d = $unsigned($signed(A) >>> shamt);
      ShiftLeftSigned:            out_d = A << shamt;
      GreaterThanOrEqualUnsigned: out_d = {{(WIDTH-1){1'b0}}, ~lt_u};
      GreaterThanOrEqualSigned:   out_d = {{(WIDTH-1){1'b0}}, ~lt_s};
      Equal:                      out_d = {{(WIDTH-1){1'b0}}, (A == B)};
      NotEqual:                   out_d = {{(WIDTH-1){1'b0}}, (A != B)};
      default:                    out_d = '0;  // opcode 15: defined as zero result
    endcase
  end

  assign Out  = out_d;
  assign Zero = (out_d == '0);

  // Reset value mirrors the undefined-opcode result: zero output, Zero flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      zero_q <= Zero;
    end
  end

  assign OutReg  = out_q;
  assign ZeroReg = zero_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [3:0]  operation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Out;
  logic        Zero;
  logic [31:0] OutReg;
  logic        ZeroReg;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 0;

  logic [31:0] exp_reg;
  logic        exp_zreg;

  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .operation(operation), .A(A), .B(B),
    .Out(Out), .Zero(Zero), .OutReg(OutReg), .ZeroReg(ZeroReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic straight from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned sh;
    logic [31:0] r;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a | b;
      4'd3:  return a ^ b;
      4'd4:  return a & b;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return a >> sh;
      4'd8:  return a << sh;
      4'd9: begin
        r = a >> sh;
        if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
      end
      4'd10: return a << sh;
      4'd11: return (a >= b) ? 32'd1 : 32'd0;
      4'd12: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd13: return (a == b) ? 32'd1 : 32'd0;
      4'd14: return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (op=%0d A=%h B=%h)", name, act, req, operation, A, B);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b (op=%0d A=%h B=%h)", name, act, req, operation, A, B);
    end
  endtask

  // Expected registered value: previous-edge model result, cleared asynchronously by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_reg  <= 32'd0;
      exp_zreg <= 1'b1;
    end else begin
      exp_reg  <= model(operation, A, B);
      exp_zreg <= (model(operation, A, B) == 32'd0);
    end
  end

  // Per-cycle compare, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (run_chk) begin
      chk32("out_vs_model", Out, model(operation, A, B));
      chk1("zero_vs_model", Zero, model(operation, A, B) == 32'd0);
      chk32("outreg_vs_model", OutReg, exp_reg);
      chk1("zeroreg_vs_model", ZeroReg, exp_zreg);
    end
  end

  // Drive a new vector just after a rising edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    operation = op;
    A = a;
    B = b;
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] req);
    apply(op, a, b);
    #2;
    chk32(name, Out, req);
    chk1({name, "_zero"}, Zero, req == 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    operation = 4'd0;
    A         = 32'd5;
    B         = 32'd7;
    #1;
    chk32("reset_outreg", OutReg, 32'd0);
    chk1("reset_zeroreg", ZeroReg, 1'b1);
    chk32("out_during_reset", Out, 32'd12);
    @(posedge clk);
    #2;
    reset = 1'b0;
    run_chk = 1'b1;

    // Hand-computed expectations.
    directed("add_wrap",   4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0);
    directed("sub_wrap",   4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF);
    directed("lts_min",    4'd6,  32'h8000_0000, 32'd1,         32'd1);
    directed("ltu_min",    4'd5,  32'h8000_0000, 32'd1,         32'd0);
    directed("ges_min",    4'd12, 32'h8000_0000, 32'd1,         32'd0);
    directed("geu_min",    4'd11, 32'h8000_0000, 32'd1,         32'd1);
    directed("sra_4",      4'd9,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    directed("srl_4",      4'd7,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    directed("sls_4",      4'd10, 32'h8000_0000, 32'h0000_0024, 32'd0);
    directed("sll_hibits", 4'd8,  32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006);
    directed("shift_0",    4'd9,  32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321);
    directed("eq",         4'd13, 32'h1234_5678, 32'h1234_5678, 32'd1);
    directed("neq",        4'd14, 32'h1234_5678, 32'h1234_5678, 32'd0);
    directed("xor_self",   4'd3,  32'h1234_5678, 32'h1234_5678, 32'd0);
    directed("and",        4'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    directed("or",         4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    directed("undef_op",   4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    directed("sra_31",     4'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF);

    // Random sweep: 32 vectors per defined opcode, plus random opcode mixes
    // where op and operands change together.
    for (int op = 0; op < 15; op++) begin
      for (int n = 0; n < 32; n++) apply(op[3:0], pick(), pick());
    end
    for (int n = 0; n < 64; n++) apply(4'($urandom_range(0, 15)), pick(), pick());

    // Reset between edges: registered outputs clear at once, combinational path untouched.
    apply(4'd0, 32'd100, 32'd23);
    @(posedge clk);
    #1;
    chk32("pre_reset_outreg", OutReg, 32'd123);
    #1;
    reset = 1'b1;
    #1;
    chk32("async_reset_outreg", OutReg, 32'd0);
    chk1("async_reset_zeroreg", ZeroReg, 1'b1);
    chk32("out_ignores_reset", Out, 32'd123);
    @(posedge clk);
    #1;
    chk32("held_reset_outreg", OutReg, 32'd0);
    operation = 4'd1;
    A = 32'd50;
    B = 32'd8;
    #1;
    reset = 1'b0;
    #1;
    chk32("post_release_outreg", OutReg, 32'd0);
    @(posedge clk);
    #1;
    chk32("first_edge_after_reset", OutReg, 32'd42);
    chk1("first_edge_after_reset_z", ZeroReg, 1'b0);

    for (int n = 0; n < 40; n++) apply(4'($urandom_range(0, 15)), pick(), pick());
    @(posedge clk);
    @(negedge clk);
    #1;
    run_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
